// File: rtl/quad_decoder_counter.sv
// quad_decoder_counter
// Quadrature (A/B) encoder decoder driving an up/down position counter.
// The asynchronous phase pins are synchronized, compared against the
// previously seen phase pair, and turned into up/down steps or an error
// pulse when both phases change between two samples. A synchronous load
// overrides any decoded movement in the same cycle.

module quad_decoder_counter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    // Warm-up lasts long enough for the synchronizer to fill with real pin
    // values and for prev to capture them, so stale zeros never decode.
    localparam int WARM_CYCLES = SYNC_STAGES + 1;
    localparam int WARM_W      = $clog2(WARM_CYCLES + 1);

    typedef enum logic {
        ST_WARMUP,
        ST_RUN
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [1:0]             cur;
    logic [1:0]             prev;
    logic [WARM_W-1:0]      warm_cnt;
    logic                   is_up;
    logic                   is_down;
    logic                   is_illegal;

    // Multi-flop synchronizers bring each asynchronous phase into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
        end
    end

    assign cur = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

    // Classify the prev->cur phase change as up, down, illegal or no change
    always_comb begin
        is_up      = 1'b0;
        is_down    = 1'b0;
        is_illegal = 1'b0;
        case ({prev, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_up      = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_down    = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: is_illegal = 1'b1;
            default: ;
        endcase
    end

    // Warm-up/run controller plus the registered counter and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_WARMUP;
            warm_cnt <= '0;
            prev     <= 2'b00;
            count    <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            err      <= 1'b0;
        end else begin
            step <= 1'b0;
            err  <= 1'b0;
            prev <= cur;
            case (state)
                ST_WARMUP: begin
                    if (load) begin
                        count <= data;
                    end
                    warm_cnt <= warm_cnt + WARM_W'(1);
                    if (warm_cnt == WARM_W'(WARM_CYCLES - 1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (load) begin
                        count <= data;
                    end else if (is_up) begin
                        count <= count + WIDTH'(1);
                        dir   <= 1'b1;
                        step  <= 1'b1;
                    end else if (is_down) begin
                        count <= count - WIDTH'(1);
                        dir   <= 1'b0;
                        step  <= 1'b1;
                    end else if (is_illegal) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_WARMUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_decoder_counter.sv
// tb_quad_decoder_counter
// Self-checking bench: directed encoder scenarios followed by a random
// encoder walk, every cycle compared against a behavioural model that
// tracks the encoder as a position on a four-state wheel.

module tb_quad_decoder_counter;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;

    logic             clk;
    logic             rst;
    logic             a_in;
    logic             b_in;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             err;

    int checkCount;
    int passCount;
    int edgeNum;
    int stepSeen;
    int errSeen;
    int firstStepEdge;
    int riseEdge;

    // behavioural model state
    logic [WIDTH-1:0] mCount;
    logic             mDir;
    logic             mStep;
    logic             mErr;
    logic [1:0]       mPrev;
    logic [1:0]       mPipe [SYNC];
    int               mWarm;

    quad_decoder_counter #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a_in(a_in),
        .b_in(b_in),
        .load(load),
        .data(data),
        .count(count),
        .dir(dir),
        .step(step),
        .err(err)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // position of an AB pair on the up wheel 00 -> 10 -> 11 -> 01
    function automatic int quadIdx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] posToAb(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, observed, expected, edgeNum);
        else
            passCount++;
    endtask

    // advance the model by one rising edge using the pin values seen there
    task automatic modelEdge(input logic a, input logic b, input logic ld, input logic [WIDTH-1:0] d, input logic r);
        logic [1:0] seen;
        int delta;
        if (r) begin
            mCount = '0;
            mDir   = 1'b0;
            mStep  = 1'b0;
            mErr   = 1'b0;
            mPrev  = 2'b00;
            mWarm  = 0;
            for (int i = 0; i < SYNC; i++) mPipe[i] = 2'b00;
        end else begin
            seen  = mPipe[SYNC-1];
            mStep = 1'b0;
            mErr  = 1'b0;
            if (mWarm < SYNC + 1) begin
                mWarm++;
                if (ld) mCount = d;
            end else if (ld) begin
                mCount = d;
            end else begin
                delta = (quadIdx(seen) - quadIdx(mPrev) + 4) % 4;
                if (delta == 1) begin
                    mCount = mCount + 1'b1;
                    mDir   = 1'b1;
                    mStep  = 1'b1;
                end else if (delta == 3) begin
                    mCount = mCount - 1'b1;
                    mDir   = 1'b0;
                    mStep  = 1'b1;
                end else if (delta == 2) begin
                    mErr = 1'b1;
                end
            end
            mPrev = seen;
            for (int i = SYNC - 1; i > 0; i--) mPipe[i] = mPipe[i-1];
            mPipe[0] = {a, b};
        end
    endtask

    // drive one cycle of inputs, clock it, then compare against the model
    task automatic applyStimulus(input logic a, input logic b, input logic ld, input logic [WIDTH-1:0] d, input logic r);
        a_in = a;
        b_in = b;
        load = ld;
        data = d;
        rst  = r;
        @(posedge clk);
        modelEdge(a, b, ld, d, r);
        edgeNum++;
        #1;
        checkOutput("count", 32'(count), 32'(mCount));
        checkOutput("dir", 32'(dir), 32'(mDir));
        checkOutput("step", 32'(step), 32'(mStep));
        checkOutput("err", 32'(err), 32'(mErr));
        if (step === 1'b1) begin
            stepSeen++;
            if (firstStepEdge == 0) firstStepEdge = edgeNum;
        end
        if (err === 1'b1) errSeen++;
    endtask

    task automatic holdPins(input logic a, input logic b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(a, b, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int pos;
        int r;
        logic [1:0] ab;
        logic ld;
        logic rs;
        checkCount    = 0;
        passCount     = 0;
        edgeNum       = 0;
        stepSeen      = 0;
        errSeen       = 0;
        firstStepEdge = 0;
        rst  = 1'b1;
        a_in = 1'b1;
        b_in = 1'b1;
        load = 1'b0;
        data = '0;
        modelEdge(1'b0, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] reset with pins held at 11");
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
        checkOutput("reset_count", 32'(count), 32'h0);
        stepSeen = 0;
        errSeen  = 0;
        holdPins(1'b1, 1'b1, 10);
        checkOutput("warm_count", 32'(count), 32'h0);
        checkOutput("warm_steps", 32'(stepSeen), 32'd0);
        checkOutput("warm_errs", 32'(errSeen), 32'd0);

        $display("[TB] up sequence from 00");
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        holdPins(1'b0, 1'b0, 6);
        stepSeen      = 0;
        firstStepEdge = 0;
        riseEdge      = edgeNum + 1;
        holdPins(1'b1, 1'b0, 4);
        holdPins(1'b1, 1'b1, 4);
        holdPins(1'b0, 1'b1, 4);
        holdPins(1'b0, 1'b0, 4);
        checkOutput("up_count", 32'(count), 32'd4);
        checkOutput("up_dir", 32'(dir), 32'd1);
        checkOutput("up_steps", 32'(stepSeen), 32'd4);
        checkOutput("up_latency", 32'(firstStepEdge - riseEdge + 1), 32'd3);

        $display("[TB] down sequence through zero");
        stepSeen = 0;
        holdPins(1'b0, 1'b1, 4);
        holdPins(1'b1, 1'b1, 4);
        holdPins(1'b1, 1'b0, 4);
        holdPins(1'b0, 1'b0, 4);
        holdPins(1'b0, 1'b1, 4);
        holdPins(1'b1, 1'b1, 4);
        checkOutput("down_count", 32'(count), 32'hFE);
        checkOutput("down_dir", 32'(dir), 32'd0);
        checkOutput("down_steps", 32'(stepSeen), 32'd6);

        $display("[TB] illegal double transition");
        holdPins(1'b1, 1'b0, 4);
        holdPins(1'b0, 1'b0, 4);
        checkOutput("pre_err_count", 32'(count), 32'hFC);
        stepSeen = 0;
        errSeen  = 0;
        holdPins(1'b1, 1'b1, 4);
        checkOutput("err_pulses", 32'(errSeen), 32'd1);
        checkOutput("err_steps", 32'(stepSeen), 32'd0);
        checkOutput("err_count", 32'(count), 32'hFC);
        checkOutput("err_dir", 32'(dir), 32'd0);
        holdPins(1'b0, 1'b1, 4);
        checkOutput("after_err_count", 32'(count), 32'hFD);
        checkOutput("after_err_dir", 32'(dir), 32'd1);

        $display("[TB] load collides with a decoded step");
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h7F, 1'b0);
        checkOutput("load_count", 32'(count), 32'h7F);
        checkOutput("load_step", 32'(step), 32'd0);
        holdPins(1'b0, 1'b0, 3);
        checkOutput("load_no_replay", 32'(count), 32'h7F);
        holdPins(1'b1, 1'b0, 4);
        checkOutput("load_next_up", 32'(count), 32'h80);

        $display("[TB] wrap up and reset mid-sequence");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
        holdPins(1'b1, 1'b0, 3);
        checkOutput("wrap_pre", 32'(count), 32'hFF);
        holdPins(1'b1, 1'b1, 4);
        checkOutput("wrap_count", 32'(count), 32'h00);
        holdPins(1'b0, 1'b1, 4);
        checkOutput("pre_rst_count", 32'(count), 32'h01);
        holdPins(1'b0, 1'b0, 1);
        stepSeen = 0;
        errSeen  = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_dir", 32'(dir), 32'd0);
        checkOutput("rst_step", 32'(step), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        holdPins(1'b0, 1'b1, 6);
        checkOutput("rst_warm_steps", 32'(stepSeen), 32'd0);
        checkOutput("rst_warm_errs", 32'(errSeen), 32'd0);
        checkOutput("rst_warm_count", 32'(count), 32'h0);

        $display("[TB] random encoder walk");
        pos = quadIdx(2'b01);
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r >= 60 && r < 75)      pos = pos + 1;
            else if (r >= 75 && r < 90) pos = pos + 3;
            else if (r >= 90 && r < 94) pos = pos + 2;
            pos = pos & 3;
            ab  = posToAb(pos);
            ld  = ($urandom_range(0, 99) < 4);
            rs  = ($urandom_range(0, 199) == 0);
            applyStimulus(ab[1], ab[0], ld, WIDTH'($urandom), rs);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
